// File: rtl/inst_mem_pipe_if.sv
// Fetch-side bundle for inst_mem_pipe: request, response, program-load and flush.
interface inst_mem_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] rsp_instr;
  logic [1:0]      rsp_fault;
  logic            load_en;
  logic [XLEN-1:0] load_addr;
  logic [XLEN-1:0] load_data;
  logic            flush;

  modport master (
    output req_valid, req_pc, rsp_ready, load_en, load_addr, load_data, flush,
    input  req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready, load_en, load_addr, load_data, flush,
    output req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/inst_mem_pipe.sv
// Pipelined instruction memory: response visible the cycle after accept, 2-deep response queue;
// req_ready drops when two responses are outstanding and returns the cycle after a pop.
module inst_mem_pipe #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 256,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter logic [XLEN-1:0] NOP_INSTR   = XLEN'(32'h0000_0013)
) (
  input logic             clk_i,
  input logic             reset_ni,
  inst_mem_pipe_if.slave  bus
);

  localparam int unsigned IDXW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [1:0]      fault;
    logic            pend;
  } slot_t;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rd_dat_q;
  slot_t           slot_q [2];
  slot_t           slot_d [2];
  slot_t           head;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      occ_q, occ_d;

  logic            req_borrow, ld_borrow;
  logic [XLEN-1:0] req_off, req_word, ld_off, ld_word;
  logic [1:0]      req_fault;
  logic            ld_ok;
  logic            accept, pop, rd_en;
  logic [IDXW-1:0] req_idx, ld_idx;

  // Offsets wrap modulo 2^XLEN; the borrow flags addresses below BASE_ADDR.
  always_comb begin
    {req_borrow, req_off} = {1'b0, bus.req_pc} - {1'b0, BASE_ADDR};
    req_word = req_off >> 2;
    req_idx  = req_word[IDXW-1:0];
    if (req_off[1:0] != 2'b00) begin
      req_fault = 2'b01;
    end else if (req_borrow || (req_word >= XLEN'(DEPTH_WORDS))) begin
      req_fault = 2'b10;
    end else begin
      req_fault = 2'b00;
    end
  end

  always_comb begin
    {ld_borrow, ld_off} = {1'b0, bus.load_addr} - {1'b0, BASE_ADDR};
    ld_word = ld_off >> 2;
    ld_idx  = ld_word[IDXW-1:0];
    ld_ok   = bus.load_en && (ld_off[1:0] == 2'b00) && !ld_borrow
              && (ld_word < XLEN'(DEPTH_WORDS));
  end

  assign bus.req_ready = reset_ni && !bus.flush && (occ_q != 2'd2);
  assign bus.rsp_valid = (occ_q != 2'd0);
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign rd_en         = accept && (req_fault == 2'b00);

  // Array is never reset; read-before-write falls out of the non-blocking update.
  always_ff @(posedge clk_i) begin
    if (ld_ok) begin
      mem_q[ld_idx] <= bus.load_data;
    end
    if (rd_en) begin
      rd_dat_q <= mem_q[req_idx];
    end
  end

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    // A pending slot takes its word from the read register one edge after the read.
    for (int i = 0; i < 2; i++) begin
      if (slot_q[i].pend) begin
        slot_d[i].instr = rd_dat_q;
        slot_d[i].pend  = 1'b0;
      end
    end
    if (bus.flush) begin
      occ_d    = 2'd0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (accept) begin
        slot_d[wr_ptr_q].pc    = bus.req_pc;
        slot_d[wr_ptr_q].fault = req_fault;
        slot_d[wr_ptr_q].instr = NOP_INSTR;
        slot_d[wr_ptr_q].pend  = (req_fault == 2'b00);
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + 2'(accept) - 2'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      occ_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      slot_q   <= slot_d;
    end
  end

  always_comb begin
    head          = slot_q[rd_ptr_q];
    bus.rsp_pc    = head.pc;
    bus.rsp_fault = head.fault;
    bus.rsp_instr = head.pend ? rd_dat_q : head.instr;
  end

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Randomised and directed bench for inst_mem_pipe against a queue-based reference model.
module tb_inst_mem_pipe;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  inst_mem_pipe_if #(.XLEN(XLEN)) bus();

  inst_mem_pipe #(
    .XLEN(XLEN), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .NOP_INSTR(NOP)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } rsp_t;

  rsp_t        mq[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] prog [4];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          last_acc;
  int          acc_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic rsp_t model_fetch(input logic [31:0] pc);
    rsp_t   r;
    longint off;
    off     = longint'(pc) - longint'(BASE);
    r.pc    = pc;
    r.instr = NOP;
    if (pc % 4 != 0) r.fault = 2'b01;
    else if (off < 0 || off / 4 >= DEPTH) r.fault = 2'b10;
    else begin
      r.fault = 2'b00;
      r.instr = mem_m[off / 4];
    end
    return r;
  endfunction

  // One clock: check outputs against the model at the falling edge, then advance the model.
  task automatic step();
    bit     exp_rdy, acc, pp;
    rsp_t   e;
    longint loff;
    @(negedge clk);
    exp_rdy = reset_n && !bus.flush && (mq.size() < 2);
    check("req_ready", bus.req_ready, exp_rdy);
    check("rsp_valid", bus.rsp_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("rsp_pc", bus.rsp_pc, mq[0].pc);
      check("rsp_instr", bus.rsp_instr, mq[0].instr);
      check("rsp_fault", bus.rsp_fault, mq[0].fault);
    end
    acc = bus.req_valid && exp_rdy;
    pp  = (mq.size() != 0) && bus.rsp_ready;
    e   = model_fetch(bus.req_pc);
    @(posedge clk);
    if (!reset_n || bus.flush) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    if (bus.load_en) begin
      loff = longint'(bus.load_addr) - longint'(BASE);
      if (bus.load_addr % 4 == 0 && loff >= 0 && loff / 4 < DEPTH) mem_m[loff / 4] = bus.load_data;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.req_pc    = pc;
    bus.req_valid = 1'b1;
    acc_cycles    = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc_cycles++;
      if (last_acc) break;
    end
    if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    repeat (4) step();
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 6) return 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (r == 7) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    if (r == 8) return 32'h400 + (32'($urandom_range(0, 1000)) << 2);
    return $urandom;
  endfunction

  initial begin
    prog[0] = 32'h00500093;
    prog[1] = 32'h00a00113;
    prog[2] = 32'h002081b3;
    prog[3] = 32'h00000013;
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.rsp_ready = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.flush     = 1'b0;

    // Program load while held in reset
    for (int w = 0; w < int'(DEPTH); w++) begin
      bus.load_en   = 1'b1;
      bus.load_addr = 32'(w) << 2;
      bus.load_data = (w < 4) ? prog[w] : $urandom;
      step();
    end
    bus.load_en = 1'b0;
    step();
    check("reset_rsp_pc", bus.rsp_pc, 32'd0);
    check("reset_rsp_instr", bus.rsp_instr, 32'd0);
    check("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset_n = 1'b1;
    #1;
    check("ready_after_release", 32'(bus.req_ready), 32'd1);

    // Back-to-back fetches
    bus.rsp_ready = 1'b1;
    fetch(32'd0);
    check("latency1_valid", 32'(bus.rsp_valid), 32'd1);
    check("latency1_instr", bus.rsp_instr, 32'h00500093);
    for (int i = 1; i < 4; i++) begin
      fetch(32'(i * 4));
      check("sustain", 32'(acc_cycles), 32'd1);
      check("b2b_instr", bus.rsp_instr, prog[i]);
    end
    drain();

    // Faults
    fetch(32'd6);
    check("misalign_fault", 32'(bus.rsp_fault), 32'd1);
    check("misalign_instr", bus.rsp_instr, 32'h00000013);
    check("misalign_pc", bus.rsp_pc, 32'd6);
    fetch(32'd1024);
    check("oor_fault", 32'(bus.rsp_fault), 32'd2);
    check("oor_instr", bus.rsp_instr, NOP);
    drain();

    // Backpressure
    bus.rsp_ready = 1'b0;
    fetch(32'd0);
    fetch(32'd4);
    bus.req_pc    = 32'd8;
    bus.req_valid = 1'b1;
    repeat (3) begin
      step();
      check("bp_no_accept", 32'(last_acc), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    check("bp_pop_no_accept", 32'(last_acc), 32'd0);
    step();
    check("bp_accept_after_pop", 32'(last_acc), 32'd1);
    bus.req_valid = 1'b0;
    drain();

    // Flush
    bus.rsp_ready = 1'b0;
    fetch(32'd0);
    fetch(32'd4);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    step();
    check("flush_no_accept", 32'(last_acc), 32'd0);
    check("flush_valid", 32'(bus.rsp_valid), 32'd0);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    fetch(32'd8);
    check("flush_refetch", bus.rsp_instr, 32'h002081b3);
    drain();

    // Same-cycle load and fetch
    bus.load_en   = 1'b1;
    bus.load_addr = 32'd4;
    bus.load_data = 32'hdeadbeef;
    fetch(32'd4);
    bus.load_en = 1'b0;
    check("rbw_old", bus.rsp_instr, 32'h00a00113);
    fetch(32'd4);
    check("rbw_new", bus.rsp_instr, 32'hdeadbeef);
    drain();

    // Reset mid-operation
    bus.rsp_ready = 1'b0;
    fetch(32'd0);
    fetch(32'd4);
    reset_n       = 1'b0;
    bus.req_valid = 1'b1;
    step();
    check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    reset_n       = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    fetch(32'd0);
    check("retain", bus.rsp_instr, 32'h00500093);
    drain();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_pc    = rand_addr();
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.load_en   = ($urandom_range(0, 9) == 0);
      bus.load_addr = rand_addr();
      bus.load_data = $urandom;
      bus.flush     = ($urandom_range(0, 29) == 0);
      reset_n       = ($urandom_range(0, 99) != 0);
      step();
    end
    reset_n       = 1'b1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.load_en   = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
